// File: rtl/rom_access_arbiter_pkg.sv
// Shared memory-system constants for the program ROM path and its arbiters.
package rom_access_arbiter_pkg;

  // Requester address width and ROM data width
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  // Number of implemented ROM locations; addresses at or above are out of range
  localparam int ROM_DEPTH = 128;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } arb_state_t;

  // Requester port indices
  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/rom_access_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick. A sole requester always wins; on a
// tie the port that did not win last time is chosen.
module rr_pick2
  import rom_access_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_any_req,
  output logic o_winner
);

  assign o_any_req = i_req0 | i_req1;

  // Select the winning port index from the current requests and last winner
  always_comb begin
    o_winner = PORT_IFETCH;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last;
    end else if (i_req1) begin
      o_winner = PORT_DATA;
    end else begin
      o_winner = PORT_IFETCH;
    end
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Two-port arbiter and sequencer for the synchronous-read program ROM.
// Port 0 is instruction fetch, port 1 is data/operand read. One access is
// outstanding at a time: IDLE (grant) -> ISSUE (ROM samples) -> CAPTURE
// (data returned with a valid pulse to the owner).
module rom_access_arbiter
  import rom_access_arbiter_pkg::*;
#(
  parameter int ADDR_W    = rom_access_arbiter_pkg::ADDR_W,
  parameter int DATA_W    = rom_access_arbiter_pkg::DATA_W,
  parameter int ROM_DEPTH = rom_access_arbiter_pkg::ROM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data_in
);

  // One extra bit so a depth equal to 2**ADDR_W is representable
  localparam logic [ADDR_W:0] ROM_LIMIT = ROM_DEPTH[ADDR_W:0];

  arb_state_t        r_state;
  logic              r_owner;
  logic              r_last;
  logic              r_oor;
  logic              r_gnt0;
  logic              r_gnt1;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rerr;
  logic [ADDR_W-1:0] r_rom_address;

  arb_state_t        w_state_nxt;
  logic              w_owner_nxt;
  logic              w_last_nxt;
  logic              w_oor_nxt;
  logic              w_gnt0_nxt;
  logic              w_gnt1_nxt;
  logic              w_rvalid0_nxt;
  logic              w_rvalid1_nxt;
  logic [DATA_W-1:0] w_rdata_nxt;
  logic              w_rerr_nxt;
  logic [ADDR_W-1:0] w_rom_address_nxt;

  logic              w_any_req;
  logic              w_winner;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_sel_oor;

  rr_pick2 u_pick (
    .i_req0    (req0),
    .i_req1    (req1),
    .i_last    (r_last),
    .o_any_req (w_any_req),
    .o_winner  (w_winner)
  );

  assign w_sel_addr = (w_winner == PORT_DATA) ? addr1 : addr0;
  // Out-of-range addresses are still driven raw to the ROM; only the result is masked
  assign w_sel_oor  = ({1'b0, w_sel_addr} >= ROM_LIMIT);

  // Next-state and next-output decode; pulse outputs default low each cycle
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_nxt        = r_last;
    w_oor_nxt         = r_oor;
    w_gnt0_nxt        = 1'b0;
    w_gnt1_nxt        = 1'b0;
    w_rvalid0_nxt     = 1'b0;
    w_rvalid1_nxt     = 1'b0;
    w_rdata_nxt       = r_rdata;
    w_rerr_nxt        = 1'b0;
    w_rom_address_nxt = r_rom_address;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_rom_address_nxt = w_sel_addr;
          w_owner_nxt       = w_winner;
          w_last_nxt        = w_winner;
          w_oor_nxt         = w_sel_oor;
          if (w_winner == PORT_DATA) begin
            w_gnt1_nxt = 1'b1;
          end else begin
            w_gnt0_nxt = 1'b1;
          end
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        // ROM samples rom_address on this edge
        w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // ROM registered data is valid now; hand it to the owner
        w_rdata_nxt = r_oor ? {DATA_W{1'b0}} : rom_data_in;
        if (r_owner == PORT_DATA) begin
          w_rvalid1_nxt = 1'b1;
        end else begin
          w_rvalid0_nxt = 1'b1;
        end
        w_rerr_nxt  = r_oor;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any outstanding read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_owner       <= PORT_IFETCH;
      r_last        <= PORT_DATA;
      r_oor         <= 1'b0;
      r_gnt0        <= 1'b0;
      r_gnt1        <= 1'b0;
      r_rvalid0     <= 1'b0;
      r_rvalid1     <= 1'b0;
      r_rdata       <= {DATA_W{1'b0}};
      r_rerr        <= 1'b0;
      r_rom_address <= {ADDR_W{1'b0}};
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last        <= w_last_nxt;
      r_oor         <= w_oor_nxt;
      r_gnt0        <= w_gnt0_nxt;
      r_gnt1        <= w_gnt1_nxt;
      r_rvalid0     <= w_rvalid0_nxt;
      r_rvalid1     <= w_rvalid1_nxt;
      r_rdata       <= w_rdata_nxt;
      r_rerr        <= w_rerr_nxt;
      r_rom_address <= w_rom_address_nxt;
    end
  end

  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign rvalid0     = r_rvalid0;
  assign rvalid1     = r_rvalid1;
  assign rdata       = r_rdata;
  assign rerr        = r_rerr;
  assign rom_address = r_rom_address;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter with a 128x8 registered-read ROM model.
module tb_rom_access_arbiter;

  logic       clk;
  logic       reset;
  logic       req0;
  logic [7:0] addr0;
  logic       req1;
  logic [7:0] addr1;
  logic       gnt0;
  logic       gnt1;
  logic       rvalid0;
  logic       rvalid1;
  logic [7:0] rdata;
  logic       rerr;
  logic [7:0] rom_address;
  logic [7:0] rom_data_in;

  logic [7:0] rom_mem [128];
  logic [7:0] exp_img [6];

  int total = 0;
  int bad   = 0;

  rom_access_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .addr0       (addr0),
    .req1        (req1),
    .addr1       (addr1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata       (rdata),
    .rerr        (rerr),
    .rom_address (rom_address),
    .rom_data_in (rom_data_in)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: one-cycle registered read
  always_ff @(posedge clk) begin
    rom_data_in <= rom_mem[rom_address[6:0]];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_img[0] = 8'h86; exp_img[1] = 8'hAA; exp_img[2] = 8'h96;
    exp_img[3] = 8'hE0; exp_img[4] = 8'h20; exp_img[5] = 8'h00;
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 6; i++) rom_mem[i] = exp_img[i];

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = 8'h00; addr1 = 8'h00;
    tick(); tick();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rerr", 32'(rerr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_romaddr", 32'(rom_address), 32'h00);

    // Reset and request together: reset wins
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rstwin_gnt0", 32'(gnt0), 32'd0);
    chk("rstwin_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    tick();

    // Single port 0 read of 0x02
    req0 = 1'b1; addr0 = 8'h02;
    tick();
    chk("p0_gnt0", 32'(gnt0), 32'd1);
    chk("p0_gnt1", 32'(gnt1), 32'd0);
    chk("p0_romaddr", 32'(rom_address), 32'h02);
    req0 = 1'b0;
    tick();
    chk("p0_gnt0_drop", 32'(gnt0), 32'd0);
    chk("p0_early_rv", 32'(rvalid0), 32'd0);
    tick();
    chk("p0_rvalid0", 32'(rvalid0), 32'd1);
    chk("p0_rdata", 32'(rdata), 32'h96);
    chk("p0_rerr", 32'(rerr), 32'd0);
    chk("p0_rvalid1", 32'(rvalid1), 32'd0);
    tick();
    chk("p0_rv_drop", 32'(rvalid0), 32'd0);
    chk("p0_rdata_hold", 32'(rdata), 32'h96);

    // Both ports held from reset: alternate 0,1,0,1 every 3 cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h00; addr1 = 8'h03;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt0", 32'(gnt0), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_gnt1", 32'(gnt1), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      chk("rr_gap_gnt", 32'({gnt0, gnt1}), 32'd0);
      tick();
      chk("rr_rvalid0", 32'(rvalid0), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_rvalid1", 32'(rvalid1), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_rdata", 32'(rdata), (k % 2 == 0) ? 32'h86 : 32'hE0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Port 1 out-of-range then last valid address
    req1 = 1'b1; addr1 = 8'h80;
    tick();
    chk("oor_gnt1", 32'(gnt1), 32'd1);
    chk("oor_romaddr", 32'(rom_address), 32'h80);
    req1 = 1'b0;
    tick();
    tick();
    chk("oor_rvalid1", 32'(rvalid1), 32'd1);
    chk("oor_rvalid0", 32'(rvalid0), 32'd0);
    chk("oor_rdata", 32'(rdata), 32'h00);
    chk("oor_rerr", 32'(rerr), 32'd1);
    req1 = 1'b1; addr1 = 8'h7F;
    tick();
    chk("top_gnt1", 32'(gnt1), 32'd1);
    chk("oor_rerr_drop", 32'(rerr), 32'd0);
    req1 = 1'b0;
    tick();
    tick();
    chk("top_rvalid1", 32'(rvalid1), 32'd1);
    chk("top_rdata", 32'(rdata), 32'h25);
    chk("top_rerr", 32'(rerr), 32'd0);

    // Reset during ISSUE of a port 0 read
    req0 = 1'b1; addr0 = 8'h01;
    tick();
    chk("mid_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_gnt0_clr", 32'(gnt0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_no_rvalid0", 32'(rvalid0), 32'd0);
    end
    // After reset the tie goes to port 0 again
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h04; addr1 = 8'h05;
    tick();
    chk("post_rst_gnt0", 32'(gnt0), 32'd1);
    chk("post_rst_gnt1", 32'(gnt1), 32'd0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    // Port 0 now in CAPTURE; port 1 raises its request
    req1 = 1'b1; addr1 = 8'h05;
    tick();
    chk("late_rvalid0", 32'(rvalid0), 32'd1);
    chk("late_rdata0", 32'(rdata), 32'h20);
    chk("late_no_gnt1", 32'(gnt1), 32'd0);
    tick();
    chk("late_gnt1", 32'(gnt1), 32'd1);
    chk("late_gnt0", 32'(gnt0), 32'd0);
    req1 = 1'b0;
    tick();
    chk("late_gnt1_once", 32'(gnt1), 32'd0);
    tick();
    chk("late_rvalid1", 32'(rvalid1), 32'd1);
    chk("late_rdata1", 32'(rdata), 32'h00);
    chk("late_rerr", 32'(rerr), 32'd0);
    tick();
    chk("late_no_dup", 32'({gnt0, gnt1, rvalid1}), 32'd0);

    // Sequential fetch 0x00..0x05 back-to-back on port 0
    for (int i = 0; i < 6; i++) begin
      req0 = 1'b1; addr0 = 8'(i);
      tick();
      chk("seq_gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      tick();
      chk("seq_gap_rv", 32'(rvalid0), 32'd0);
      tick();
      chk("seq_rvalid0", 32'(rvalid0), 32'd1);
      chk("seq_rdata", 32'(rdata), 32'(exp_img[i]));
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
